cel: RTL and testbench
======================

CEL -- requirements
Module: cel

Interface
REQ-001 The module SHALL have no parameters; all widths are fixed as listed below.
REQ-002 clk  input  1  single clock; the only clocked element is the cell flip-flop.
REQ-003 rst_n  input  1  reset, asynchronous and active-low; clears the cell flip-flop.
REQ-004 ctr  input  31  static configuration word, applied combinationally and not latched.
REQ-005 cbi  input  2  connection-block input tracks.
REQ-006 sbi  input  6  switch-block input tracks.
REQ-007 cbo  output  2  connection-block outputs; cbo[0] = cell output, cbo[1] = flip-flop Q.
REQ-008 sbo  output  6  switch-block outputs.

Function
REQ-009 The input source pool SHALL be the 3-bit code s: 0 -> cbi[0], 1 -> cbi[1], 2..7 -> sbi[s-2].
REQ-010 Each LUT input SHALL come from a 3-bit selector in ctr:
- in0 <- ctr[19:17]
- in1 <- ctr[22:20]
- in2 <- ctr[25:23]
- in3 <- ctr[28:26]
REQ-011 LUT index SHALL be idx = {in3,in2,in1,in0}; lut_out SHALL be ctr[idx] (ctr[15:0] is the truth table, bit 0 = all inputs 0).
REQ-012 The flip-flop SHALL capture lut_out on every rising clk edge; there is no enable.
REQ-013 Flip-flop Q SHALL be 0 while rst_n = 0, independent of clk.
REQ-014 The cell output SHALL be Q when ctr[16] = 1 and lut_out when ctr[16] = 0.
REQ-015 cbo[0] SHALL equal the cell output; cbo[1] SHALL equal Q.
REQ-016 sbo SHALL follow ctr[30:29]; lanes not listed equal the matching sbi bit:
- 00 -> sbo = sbi
- 01 -> sbo[0] and sbo[3] = cell output
- 10 -> sbo[1] and sbo[4] = cell output
- 11 -> sbo[2] and sbo[5] = cell output
REQ-017 All paths except the flip-flop SHALL be purely combinational.
- Latency from any of ctr, cbi, sbi to cbo[0] or sbo is zero cycles when ctr[16] = 0.
- Latency is one clk edge when ctr[16] = 1.
REQ-018 Selecting the same source for several LUT inputs SHALL be legal; the duplicated inputs carry identical values.
REQ-019 Configuration changes mid-operation SHALL take effect immediately on the combinational paths; they affect Q only at the next edge.
REQ-020 Outputs SHALL never be X or Z when all inputs are known; there are no tristates and no latches.

Reset
REQ-021 While rst_n = 0, Q SHALL be 0, so:
- cbo[1] = 0;
- cbo[0] and any sbo lane driven by the cell output are 0 when ctr[16] = 1.
REQ-022 While rst_n = 0, combinational paths SHALL keep operating.
REQ-023 Reset assertion SHALL take effect immediately; release SHALL be synchronous-safe, with the first capture on the first rising edge after deassertion.
REQ-024 ctr has no reset and its value SHALL be supplied externally.

Verification
REQ-025 Bench scenario, all-zero inputs: ctr=0, cbi=0, sbi=0 -> cbo=00, sbo=000000 (LUT bit 0 = 0).
REQ-026 Bench scenario, unregistered path with cbi=3: ctr=999 (0x3E7), cbi=3, sbi=1 -> idx=15, lut_out=0, sbo=000001; cbo=00 after one clk edge (before any edge following reset, cbo[1]=0).
REQ-027 Bench scenario, unregistered path with cbi=0: ctr=999, cbi=0, sbi=0 -> idx=0, cbo[0]=1 immediately; cbo[1]=1 after the next rising clk.
REQ-028 Bench scenario, registered path: ctr[16]=1, truth table 0xFFFF -> cbo[0] and cbo[1] stay 0 until the first rising clk after rst_n release, then become 1.
- Asserting rst_n=0 mid-run drops both to 0 without a clock edge.
REQ-029 Bench scenario, switch routing: ctr[30:29]=10, cell output 1, sbi=000000 -> sbo=010010.
- With ctr[30:29]=00 -> sbo=000000.
REQ-030 Bench scenario, selector sweep: for each code s = 0..7 on in0 with truth table 0xAAAA, toggle only the selected source -> cbo[0] follows it combinationally.

Source files
------------

// File: rtl/cel.sv
// ============================================================================
// cel: 4-input LUT logic cell with optional output register and track routing
// Revision: 1.0
// ============================================================================
`default_nettype none

module cel (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [30:0] ctr,
    input  logic [1:0]  cbi,
    input  logic [5:0]  sbi,
    output logic [1:0]  cbo,
    output logic [5:0]  sbo
);

    logic [7:0]  w_pool;
    logic [15:0] w_truth;
    logic [3:0]  w_idx;
    logic        w_lut;
    logic        w_cell;
    logic        q_d;
    logic        q_q;

    // Source code s maps straight to pool bit s: 0,1 are cbi, 2..7 are sbi[s-2].
    assign w_pool  = {sbi, cbi};
    assign w_truth = ctr[15:0];

    assign w_idx = {w_pool[ctr[28:26]],
                    w_pool[ctr[25:23]],
                    w_pool[ctr[22:20]],
                    w_pool[ctr[19:17]]};

    assign w_lut = w_truth[w_idx];
    assign q_d   = w_lut;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q <= 1'b0;
        end else begin
            q_q <= q_d;
        end
    end

    assign w_cell = ctr[16] ? q_q : w_lut;
    assign cbo    = {q_q, w_cell};

    always_comb begin
        sbo = sbi;
        case (ctr[30:29])
            2'b01: begin
                sbo[0] = w_cell;
                sbo[3] = w_cell;
            end
            2'b10: begin
                sbo[1] = w_cell;
                sbo[4] = w_cell;
            end
            2'b11: begin
                sbo[2] = w_cell;
                sbo[5] = w_cell;
            end
            default: begin
                sbo = sbi;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_cel.sv
// ============================================================================
// tb_cel: directed scoreboard bench for the cel logic cell
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_cel;

    logic        clk;
    logic        rst_n;
    logic [30:0] ctr;
    logic [1:0]  cbi;
    logic [5:0]  sbi;
    logic [1:0]  cbo;
    logic [5:0]  sbo;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string      tag;
        logic [1:0] cbo;
        logic [5:0] sbo;
        logic [1:0] mask;
    } exp_t;

    exp_t sb_q[$];

    cel u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ctr   (ctr),
        .cbi   (cbi),
        .sbi   (sbi),
        .cbo   (cbo),
        .sbo   (sbo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic push_exp(input string tag, input logic [1:0] e_cbo,
                            input logic [5:0] e_sbo, input logic [1:0] mask);
        exp_t e;
        e.tag  = tag;
        e.cbo  = e_cbo;
        e.sbo  = e_sbo;
        e.mask = mask;
        sb_q.push_back(e);
    endtask

    task automatic pop_check();
        exp_t e;
        if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL scoreboard_empty: observed 0 entries, expected at least 1");
        end else begin
            e = sb_q.pop_front();
            checks++;
            assert (((cbo & e.mask) === (e.cbo & e.mask)) && (sbo === e.sbo)) else begin
                errors++;
                $error("FAIL %s: observed cbo=%b sbo=%b, expected cbo=%b (mask %b) sbo=%b",
                       e.tag, cbo, sbo, e.cbo, e.mask, e.sbo);
            end
        end
    endtask

    // Push expectation, let combinational logic settle, then compare.
    task automatic step(input string tag, input logic [1:0] e_cbo,
                        input logic [5:0] e_sbo, input logic [1:0] mask);
        push_exp(tag, e_cbo, e_sbo, mask);
        #1;
        pop_check();
    endtask

    initial begin
        logic [7:0] src;
        string      tag;

        rst_n = 1'b0;
        ctr   = '0;
        cbi   = '0;
        sbi   = '0;

        // All-zero inputs under reset.
        @(negedge clk);
        step("reset_all_zero", 2'b00, 6'b000000, 2'b11);

        // ctr=999, cbi=3: idx 15, lut_out 0, sbo passes sbi.
        ctr = 31'h3E7;
        cbi = 2'b11;
        sbi = 6'b000001;
        step("c999_cbi3_in_reset", 2'b00, 6'b000001, 2'b11);
        @(negedge clk);
        rst_n = 1'b1;
        step("c999_cbi3_released", 2'b00, 6'b000001, 2'b11);
        @(posedge clk);
        step("c999_cbi3_after_edge", 2'b00, 6'b000001, 2'b11);

        // ctr=999, cbi=0: idx 0, lut_out 1 at once, Q one edge later.
        @(negedge clk);
        cbi = 2'b00;
        sbi = 6'b000000;
        step("c999_cbi0_comb", 2'b01, 6'b000000, 2'b11);
        @(posedge clk);
        step("c999_cbi0_reg", 2'b11, 6'b000000, 2'b11);

        // Registered path, truth table all ones.
        @(negedge clk);
        rst_n = 1'b0;
        ctr   = 31'h0001_FFFF;
        step("reg_in_reset", 2'b00, 6'b000000, 2'b11);
        @(negedge clk);
        rst_n = 1'b1;
        step("reg_released", 2'b00, 6'b000000, 2'b11);
        @(posedge clk);
        step("reg_first_edge", 2'b11, 6'b000000, 2'b11);
        #2;
        rst_n = 1'b0;
        step("reg_async_reset", 2'b00, 6'b000000, 2'b11);
        @(negedge clk);
        rst_n = 1'b1;

        // Switch-block routing with combinational cell output.
        @(negedge clk);
        ctr = (31'd2 << 29) | 31'h0000_FFFF;
        sbi = 6'b000000;
        step("route_10", 2'b01, 6'b010010, 2'b01);
        ctr = 31'h0000_FFFF;
        step("route_00", 2'b01, 6'b000000, 2'b01);
        ctr = (31'd1 << 29);
        sbi = 6'b111111;
        step("route_01_zero", 2'b00, 6'b110110, 2'b01);
        ctr = (31'd3 << 29);
        step("route_11_zero", 2'b00, 6'b011011, 2'b01);

        // Selector sweep on in0 with truth table 0xAAAA (lut_out = in0).
        for (int s = 0; s < 8; s++) begin
            @(negedge clk);
            ctr = (31'(s) << 17) | 31'h0000_AAAA;
            src = 8'(1 << s);
            {sbi, cbi} = ~src;
            tag = $sformatf("sweep_s%0d_low", s);
            step(tag, 2'b00, ~src[7:2], 2'b01);
            {sbi, cbi} = src;
            tag = $sformatf("sweep_s%0d_high", s);
            step(tag, 2'b01, src[7:2], 2'b01);
        end

        // Same source on every LUT input: only idx 0 or 15 reachable.
        @(negedge clk);
        ctr = (31'd5 << 26) | (31'd5 << 23) | (31'd5 << 20) | (31'd5 << 17) | 31'h0000_8000;
        sbi = 6'b001000;
        cbi = 2'b00;
        step("dup_src_high", 2'b01, 6'b001000, 2'b01);
        sbi = 6'b110111;
        step("dup_src_low", 2'b00, 6'b110111, 2'b01);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
